triangle_setup: RTL and testbench



---
 rtl/triangle_setup_if.sv | 20 ++
 rtl/triangle_setup.sv | 241 ++++++++++++++++++++++++
 tb/tb_triangle_setup.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/triangle_setup_if.sv
// Triangle input channel: valid/ready handshake plus the three vertices.
interface triangle_setup_if;
  logic       tri_valid;
  logic       tri_ready;
  logic [8:0] x0, x1, x2;
  logic [7:0] y0, y1, y2;
  logic [7:0] z0, z1, z2;

  // Upstream producer of triangles
  modport master (
    output tri_valid, x0, x1, x2, y0, y1, y2, z0, z1, z2,
    input  tri_ready
  );

  // Setup stage consuming triangles
  modport slave (
    input  tri_valid, x0, x1, x2, y0, y1, y2, z0, z1, z2,
    output tri_ready
  );
endinterface

// File: rtl/triangle_setup.sv
// Triangle setup: edge equations, doubled area, clamped bbox, culling and
// rasterizer launch. Outputs are held from ORIENT exit until the rasterizer
// reports done; they only change again in EDGE/ORIENT of the next triangle.
module triangle_setup #(
  parameter int SCREEN_W  = 320,
  parameter int SCREEN_H  = 240,
  parameter int CULL_BACK = 0
) (
  input  logic              clk,
  input  logic              reset,
  triangle_setup_if.slave   tri_if,
  output logic signed [8:0]  a1, a2, a3,
  output logic signed [9:0]  b1, b2, b3,
  output logic signed [17:0] c1, c2, c3,
  output logic signed [19:0] area2,
  output logic [7:0]         zv0, zv1, zv2,
  output logic [8:0]         bbxi, bbxf,
  output logic [7:0]         bbyi, bbyf,
  output logic               rasterizer_start,
  input  logic               rasterizer_done,
  output logic               tri_culled,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PROD   = 3'd1,
    S_EDGE   = 3'd2,
    S_ORIENT = 3'd3,
    S_START  = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

  localparam logic [8:0] XMAX = 9'(SCREEN_W - 1);
  localparam logic [8:0] YMAX = 9'(SCREEN_H - 1);

  state_t state_q, state_d;

  logic [8:0]  x0_q, x1_q, x2_q, x0_d, x1_d, x2_d;
  logic [7:0]  y0_q, y1_q, y2_q, y0_d, y1_d, y2_d;
  logic [7:0]  z0_q, z1_q, z2_q, z0_d, z1_d, z2_d;
  logic [16:0] p01_q, p10_q, p12_q, p21_q, p20_q, p02_q;
  logic [16:0] p01_d, p10_d, p12_d, p21_d, p20_d, p02_d;
  logic [8:0]  a1_q, a2_q, a3_q, a1_d, a2_d, a3_d;
  logic [9:0]  b1_q, b2_q, b3_q, b1_d, b2_d, b3_d;
  logic [17:0] c1_q, c2_q, c3_q, c1_d, c2_d, c3_d;
  logic [19:0] area2_q, area2_d;
  logic [7:0]  zv0_q, zv1_q, zv2_q, zv0_d, zv1_d, zv2_d;
  logic [8:0]  bbxi_q, bbxf_q, bbxi_d, bbxf_d;
  logic [7:0]  bbyi_q, bbyf_q, bbyi_d, bbyf_d;

  // Edge-stage combinational results
  logic [8:0]  a1_e, a2_e, a3_e;
  logic [9:0]  b1_e, b2_e, b3_e;
  logic [17:0] c1_e, c2_e, c3_e;
  logic [19:0] area_e;
  logic [8:0]  bbxi_e, bbxf_e, byi9_e, byf9_e;

  logic cull_s, ready_s, busy_s, start_s, culled_s;

  function automatic logic [8:0] min3(input logic [8:0] a, input logic [8:0] b,
                                      input logic [8:0] c);
    logic [8:0] m;
    if (a < b) m = a; else m = b;
    if (c < m) m = c; else m = m;
    return m;
  endfunction

  function automatic logic [8:0] max3(input logic [8:0] a, input logic [8:0] b,
                                      input logic [8:0] c);
    logic [8:0] m;
    if (a > b) m = a; else m = b;
    if (c > m) m = c; else m = m;
    return m;
  endfunction

  function automatic logic [8:0] clamp9(input logic [8:0] v, input logic [8:0] lim);
    if (v > lim) return lim;
    else return v;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Drop zero-area triangles, and back-facing ones when culling is enabled
  always_comb begin
    cull_s = 1'b0;
    if (area2_q == 20'd0) cull_s = 1'b1;
    else if (area2_q[19] && (CULL_BACK != 0)) cull_s = 1'b1;
    else cull_s = 1'b0;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tri_if.tri_valid) state_d = S_PROD; else state_d = S_IDLE;
      S_PROD:   state_d = S_EDGE;
      S_EDGE:   state_d = S_ORIENT;
      S_ORIENT: if (cull_s) state_d = S_IDLE; else state_d = S_START;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (rasterizer_done) state_d = S_IDLE; else state_d = S_WAIT;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state
  always_comb begin
    ready_s  = 1'b0;
    busy_s   = 1'b1;
    start_s  = 1'b0;
    culled_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
      S_ORIENT: culled_s = cull_s;
      S_START:  start_s  = 1'b1;
      default:  start_s  = 1'b0;
    endcase
  end

  // Edge equations, doubled area and clamped bounding box from latched vertices
  always_comb begin
    a1_e   = {1'b0, y0_q} - {1'b0, y1_q};
    a2_e   = {1'b0, y1_q} - {1'b0, y2_q};
    a3_e   = {1'b0, y2_q} - {1'b0, y0_q};
    b1_e   = {1'b0, x1_q} - {1'b0, x0_q};
    b2_e   = {1'b0, x2_q} - {1'b0, x1_q};
    b3_e   = {1'b0, x0_q} - {1'b0, x2_q};
    c1_e   = {1'b0, p01_q} - {1'b0, p10_q};
    c2_e   = {1'b0, p12_q} - {1'b0, p21_q};
    c3_e   = {1'b0, p20_q} - {1'b0, p02_q};
    area_e = {{2{c1_e[17]}}, c1_e} + {{2{c2_e[17]}}, c2_e} + {{2{c3_e[17]}}, c3_e};
    bbxi_e = clamp9(min3(x0_q, x1_q, x2_q), XMAX);
    bbxf_e = clamp9(max3(x0_q, x1_q, x2_q), XMAX);
    byi9_e = clamp9(min3({1'b0, y0_q}, {1'b0, y1_q}, {1'b0, y2_q}), YMAX);
    byf9_e = clamp9(max3({1'b0, y0_q}, {1'b0, y1_q}, {1'b0, y2_q}), YMAX);
  end

  // Datapath next state: latch on accept, products, edge load, orientation
  always_comb begin
    x0_d = x0_q;  x1_d = x1_q;  x2_d = x2_q;
    y0_d = y0_q;  y1_d = y1_q;  y2_d = y2_q;
    z0_d = z0_q;  z1_d = z1_q;  z2_d = z2_q;
    p01_d = p01_q; p10_d = p10_q; p12_d = p12_q;
    p21_d = p21_q; p20_d = p20_q; p02_d = p02_q;
    a1_d = a1_q;  a2_d = a2_q;  a3_d = a3_q;
    b1_d = b1_q;  b2_d = b2_q;  b3_d = b3_q;
    c1_d = c1_q;  c2_d = c2_q;  c3_d = c3_q;
    area2_d = area2_q;
    zv0_d = zv0_q; zv1_d = zv1_q; zv2_d = zv2_q;
    bbxi_d = bbxi_q; bbxf_d = bbxf_q; bbyi_d = bbyi_q; bbyf_d = bbyf_q;
    case (state_q)
      S_IDLE: begin
        if (tri_if.tri_valid) begin
          x0_d = tri_if.x0; x1_d = tri_if.x1; x2_d = tri_if.x2;
          y0_d = tri_if.y0; y1_d = tri_if.y1; y2_d = tri_if.y2;
          z0_d = tri_if.z0; z1_d = tri_if.z1; z2_d = tri_if.z2;
        end else begin
          x0_d = x0_q;
        end
      end
      S_PROD: begin
        p01_d = {8'd0, x0_q} * {9'd0, y1_q};
        p10_d = {8'd0, x1_q} * {9'd0, y0_q};
        p12_d = {8'd0, x1_q} * {9'd0, y2_q};
        p21_d = {8'd0, x2_q} * {9'd0, y1_q};
        p20_d = {8'd0, x2_q} * {9'd0, y0_q};
        p02_d = {8'd0, x0_q} * {9'd0, y2_q};
      end
      S_EDGE: begin
        a1_d = a1_e; a2_d = a2_e; a3_d = a3_e;
        b1_d = b1_e; b2_d = b2_e; b3_d = b3_e;
        c1_d = c1_e; c2_d = c2_e; c3_d = c3_e;
        area2_d = area_e;
        zv0_d = z0_q; zv1_d = z1_q; zv2_d = z2_q;
        bbxi_d = bbxi_e; bbxf_d = bbxf_e;
        bbyi_d = byi9_e[7:0]; bbyf_d = byf9_e[7:0];
      end
      S_ORIENT: begin
        // Reorient clockwise triangles so every interior edge value is >= 0
        if (area2_q[19] && !cull_s) begin
          a1_d = 9'd0 - a1_q;   a2_d = 9'd0 - a2_q;   a3_d = 9'd0 - a3_q;
          b1_d = 10'd0 - b1_q;  b2_d = 10'd0 - b2_q;  b3_d = 10'd0 - b3_q;
          c1_d = 18'd0 - c1_q;  c2_d = 18'd0 - c2_q;  c3_d = 18'd0 - c3_q;
          area2_d = 20'd0 - area2_q;
        end else begin
          area2_d = area2_q;
        end
      end
      default: area2_d = area2_q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q <= 9'd0;  x1_q <= 9'd0;  x2_q <= 9'd0;
      y0_q <= 8'd0;  y1_q <= 8'd0;  y2_q <= 8'd0;
      z0_q <= 8'd0;  z1_q <= 8'd0;  z2_q <= 8'd0;
      p01_q <= 17'd0; p10_q <= 17'd0; p12_q <= 17'd0;
      p21_q <= 17'd0; p20_q <= 17'd0; p02_q <= 17'd0;
      a1_q <= 9'd0;  a2_q <= 9'd0;  a3_q <= 9'd0;
      b1_q <= 10'd0; b2_q <= 10'd0; b3_q <= 10'd0;
      c1_q <= 18'd0; c2_q <= 18'd0; c3_q <= 18'd0;
      area2_q <= 20'd0;
      zv0_q <= 8'd0; zv1_q <= 8'd0; zv2_q <= 8'd0;
      bbxi_q <= 9'd0; bbxf_q <= 9'd0; bbyi_q <= 8'd0; bbyf_q <= 8'd0;
    end else begin
      x0_q <= x0_d;  x1_q <= x1_d;  x2_q <= x2_d;
      y0_q <= y0_d;  y1_q <= y1_d;  y2_q <= y2_d;
      z0_q <= z0_d;  z1_q <= z1_d;  z2_q <= z2_d;
      p01_q <= p01_d; p10_q <= p10_d; p12_q <= p12_d;
      p21_q <= p21_d; p20_q <= p20_d; p02_q <= p02_d;
      a1_q <= a1_d;  a2_q <= a2_d;  a3_q <= a3_d;
      b1_q <= b1_d;  b2_q <= b2_d;  b3_q <= b3_d;
      c1_q <= c1_d;  c2_q <= c2_d;  c3_q <= c3_d;
      area2_q <= area2_d;
      zv0_q <= zv0_d; zv1_q <= zv1_d; zv2_q <= zv2_d;
      bbxi_q <= bbxi_d; bbxf_q <= bbxf_d; bbyi_q <= bbyi_d; bbyf_q <= bbyf_d;
    end
  end

  assign tri_if.tri_ready = ready_s;
  assign busy             = busy_s;
  assign rasterizer_start = start_s;
  assign tri_culled       = culled_s;
  assign a1 = a1_q;  assign a2 = a2_q;  assign a3 = a3_q;
  assign b1 = b1_q;  assign b2 = b2_q;  assign b3 = b3_q;
  assign c1 = c1_q;  assign c2 = c2_q;  assign c3 = c3_q;
  assign area2 = area2_q;
  assign zv0 = zv0_q; assign zv1 = zv1_q; assign zv2 = zv2_q;
  assign bbxi = bbxi_q; assign bbxf = bbxf_q;
  assign bbyi = bbyi_q; assign bbyf = bbyf_q;

endmodule

// File: tb/tb_triangle_setup.sv
// Bench for triangle_setup: one instance per CULL_BACK setting, sharing all
// stimulus, checked cycle by cycle against an integer reference model.
module tb_triangle_setup;

  logic       clk = 1'b0;
  logic       reset;
  logic       tri_valid;
  logic       done;
  logic [8:0] xs [3];
  logic [7:0] ys [3];
  logic [7:0] zs [3];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    triangle_setup_if tif ();
    logic [8:0]   a1, a2, a3;
    logic [9:0]   b1, b2, b3;
    logic [17:0]  c1, c2, c3;
    logic [19:0]  ar;
    logic [7:0]   zv0, zv1, zv2;
    logic [8:0]   bxi, bxf;
    logic [7:0]   byi, byf;
    logic         start, culled, busy;
    logic [188:0] vec;
    logic [3:0]   st;

    assign tif.tri_valid = tri_valid;
    assign tif.x0 = xs[0];
    assign tif.x1 = xs[1];
    assign tif.x2 = xs[2];
    assign tif.y0 = ys[0];
    assign tif.y1 = ys[1];
    assign tif.y2 = ys[2];
    assign tif.z0 = zs[0];
    assign tif.z1 = zs[1];
    assign tif.z2 = zs[2];

    triangle_setup #(.SCREEN_W(320), .SCREEN_H(240), .CULL_BACK(g)) dut (
      .clk(clk), .reset(reset), .tri_if(tif),
      .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
      .c1(c1), .c2(c2), .c3(c3), .area2(ar),
      .zv0(zv0), .zv1(zv1), .zv2(zv2),
      .bbxi(bxi), .bbxf(bxf), .bbyi(byi), .bbyf(byf),
      .rasterizer_start(start), .rasterizer_done(done),
      .tri_culled(culled), .busy(busy)
    );

    assign vec = {a1, a2, a3, b1, b2, b3, c1, c2, c3, ar, zv0, zv1, zv2, bxi, bxf, byi, byf};
    assign st  = {start, culled, busy, tif.tri_ready};
  end

  function automatic logic [3:0] st_of(input int g);
    if (g == 0) return g_dut[0].st;
    else return g_dut[1].st;
  endfunction

  function automatic logic [188:0] vec_of(input int g);
    if (g == 0) return g_dut[0].vec;
    else return g_dut[1].vec;
  endfunction

  // Reference: plain integer geometry from the vertex coordinates
  function automatic void model(input int x0, y0, z0, x1, y1, z1, x2, y2, z2,
                                input bit cb, output logic [188:0] v,
                                output bit launch, output bit cull);
    int a[3], b[3], c[3], ar, xmn, xmx, ymn, ymx;
    a[0] = y0 - y1; a[1] = y1 - y2; a[2] = y2 - y0;
    b[0] = x1 - x0; b[1] = x2 - x1; b[2] = x0 - x2;
    c[0] = x0 * y1 - x1 * y0;
    c[1] = x1 * y2 - x2 * y1;
    c[2] = x2 * y0 - x0 * y2;
    ar = c[0] + c[1] + c[2];
    cull = (ar == 0) || (ar < 0 && cb);
    launch = !cull;
    if (ar < 0) begin
      ar = -ar;
      for (int i = 0; i < 3; i++) begin
        a[i] = -a[i]; b[i] = -b[i]; c[i] = -c[i];
      end
    end
    xmn = (x0 < x1) ? x0 : x1; xmn = (x2 < xmn) ? x2 : xmn;
    xmx = (x0 > x1) ? x0 : x1; xmx = (x2 > xmx) ? x2 : xmx;
    ymn = (y0 < y1) ? y0 : y1; ymn = (y2 < ymn) ? y2 : ymn;
    ymx = (y0 > y1) ? y0 : y1; ymx = (y2 > ymx) ? y2 : ymx;
    if (xmn > 319) xmn = 319;
    if (xmx > 319) xmx = 319;
    if (ymn > 239) ymn = 239;
    if (ymx > 239) ymx = 239;
    v = {a[0][8:0], a[1][8:0], a[2][8:0], b[0][9:0], b[1][9:0], b[2][9:0],
         c[0][17:0], c[1][17:0], c[2][17:0], ar[19:0], z0[7:0], z1[7:0], z2[7:0],
         xmn[8:0], xmx[8:0], ymn[7:0], ymx[7:0]};
  endfunction

  // Present one triangle and follow both instances through their whole flow.
  // done_at: negedge index (after accept) where rasterizer_done is raised.
  task automatic run_tri(input int x0, y0, z0, x1, y1, z1, x2, y2, z2,
                         input int done_at, input bit hold_valid);
    logic [188:0] ev [2];
    bit           ln [2];
    bit           cl [2];
    logic [3:0]   es;
    int           idle_k;
    for (int g = 0; g < 2; g++)
      model(x0, y0, z0, x1, y1, z1, x2, y2, z2, bit'(g), ev[g], ln[g], cl[g]);
    idle_k = ((done_at > 5) ? done_at : 5) + 1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (st_of(g) !== 4'b0001) begin
        errors++;
        $display("FAIL idle_before_accept g=%0d got=%b exp=0001", g, st_of(g));
      end
    end
    xs[0] = 9'(x0); xs[1] = 9'(x1); xs[2] = 9'(x2);
    ys[0] = 8'(y0); ys[1] = 8'(y1); ys[2] = 8'(y2);
    zs[0] = 8'(z0); zs[1] = 8'(z1); zs[2] = 8'(z2);
    tri_valid = 1'b1;
    done = (done_at <= 0);
    for (int k = 1; k <= idle_k; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        es[3] = ln[g] && (k == 4);
        es[2] = cl[g] && (k == 3);
        es[1] = (k <= 3) || (ln[g] && k < idle_k);
        es[0] = !es[1];
        checks++;
        if (st_of(g) !== es) begin
          errors++;
          $display("FAIL flow g=%0d k=%0d start/cull/busy/ready got=%b exp=%b", g, k, st_of(g), es);
        end
        if (ln[g] && (k == 4 || k == idle_k - 1 || k == idle_k)) begin
          checks++;
          if (vec_of(g) !== ev[g]) begin
            errors++;
            $display("FAIL outputs g=%0d k=%0d got=%h exp=%h", g, k, vec_of(g), ev[g]);
          end
        end
      end
      tri_valid = hold_valid && (k < idle_k - 1);
      if (k == done_at) done = 1'b1;
    end
    done = 1'b0;
    tri_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (st_of(g) !== 4'b0001) begin
        errors++;
        $display("FAIL %s_status g=%0d got=%b exp=0001", name, g, st_of(g));
      end
      checks++;
      if (vec_of(g) !== 189'd0) begin
        errors++;
        $display("FAIL %s_outputs g=%0d got=%h exp=0", name, g, vec_of(g));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tri_valid = 1'b0; done = 1'b0;
    for (int i = 0; i < 3; i++) begin xs[i] = 9'd0; ys[i] = 8'd0; zs[i] = 8'd0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("reset");
  endtask

  task automatic test_basic();
    run_tri(10, 10, 5, 50, 10, 6, 10, 40, 7, 7, 1'b0);
    checks++;
    if (g_dut[0].ar !== 20'd1200) begin
      errors++;
      $display("FAIL basic_area2 got=%0d exp=1200", g_dut[0].ar);
    end
  endtask

  task automatic test_backface();
    run_tri(10, 10, 1, 10, 40, 2, 50, 10, 3, 6, 1'b0);
  endtask

  task automatic test_collinear();
    run_tri(0, 0, 9, 10, 10, 9, 20, 20, 9, 6, 1'b0);
  endtask

  task automatic test_clamp();
    run_tri(10, 10, 4, 400, 20, 5, 30, 250, 6, 8, 1'b0);
    checks++;
    if (g_dut[0].bxf !== 9'd319 || g_dut[0].byf !== 8'd239) begin
      errors++;
      $display("FAIL clamp bbxf=%0d bbyf=%0d exp=319/239", g_dut[0].bxf, g_dut[0].byf);
    end
  endtask

  task automatic test_done_hold();
    run_tri(20, 30, 11, 90, 35, 12, 40, 100, 13, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_tri(5, 5, 1, 60, 8, 2, 15, 70, 3, 5, 1'b0);
    run_tri(100, 50, 4, 120, 90, 5, 300, 60, 6, 5, 1'b0);
    run_tri(0, 0, 7, 511, 255, 8, 0, 255, 9, 5, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    xs[0] = 9'd10; xs[1] = 9'd50; xs[2] = 9'd10;
    ys[0] = 8'd10; ys[1] = 8'd10; ys[2] = 8'd40;
    zs[0] = 8'd5;  zs[1] = 8'd6;  zs[2] = 8'd7;
    tri_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      tri_valid = 1'b0;
    end
    checks++;
    if (st_of(0) !== 4'b0010) begin
      errors++;
      $display("FAIL wait_before_reset got=%b exp=0010", st_of(0));
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("reset_in_wait");
    done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_values("done_after_reset");
    end
    done = 1'b0;
  endtask

  task automatic test_random();
    int v [9];
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 3; i++) begin
        v[3*i]     = int'($urandom_range(0, 511));
        v[3*i + 1] = int'($urandom_range(0, 255));
        v[3*i + 2] = int'($urandom_range(0, 255));
      end
      run_tri(v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7], v[8],
              int'($urandom_range(0, 9)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backface();
    test_collinear();
    test_clamp();
    test_done_hold();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
